// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW hazard stall/flush control for the 5-stage pipe
// Optional feature macro: PIPE_FORWARDING_EN (load-use-only stalls plus registered forwarding selects).

module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_we,
  input  logic              br_taken,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              hz_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, flush_q, consec_q;
  logic             hz_err_q;
  logic             a_ex_hit, b_ex_hit, a_mem_hit, b_mem_hit, hazard;

  // Register 0 is hardwired zero, so it never creates a dependency.
  assign a_ex_hit  = id_valid & id_use_rs & ex_we  & (ex_wreg  == id_rs) & (id_rs != '0);
  assign b_ex_hit  = id_valid & id_use_rt & ex_we  & (ex_wreg  == id_rt) & (id_rt != '0);
  assign a_mem_hit = id_valid & id_use_rs & mem_we & (mem_wreg == id_rs) & (id_rs != '0);
  assign b_mem_hit = id_valid & id_use_rt & mem_we & (mem_wreg == id_rt) & (id_rt != '0);

`ifdef PIPE_FORWARDING_EN
  // Bypass paths cover every result except a load still in EX.
  assign hazard = ex_is_load & (a_ex_hit | b_ex_hit);
`else
  logic unused_ex_is_load;
  assign unused_ex_is_load = ex_is_load;
  assign hazard = a_ex_hit | b_ex_hit | a_mem_hit | b_mem_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = ST_RUN;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (br_taken) begin
      state_d     = ST_FLUSH;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      state_d     = ST_STALL;
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
    // Control must drop the moment reset rises, not at the next edge.
    if (reset) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= '0;
      flush_q  <= '0;
      consec_q <= '0;
      hz_err_q <= 1'b0;
    end else begin
      if (pc_hold && stall_q != CNT_MAX) stall_q <= stall_q + 1'b1;
      if (br_taken && flush_q != CNT_MAX) flush_q <= flush_q + 1'b1;
      if (pc_hold) begin
        if (consec_q != CNT_MAX) consec_q <= consec_q + 1'b1;
        if (consec_q >= CNT_W'(MAX_STALL)) hz_err_q <= 1'b1;
      end else begin
        consec_q <= '0;
      end
    end
  end

`ifdef PIPE_FORWARDING_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  // Selects travel with the instruction entering ID/EX; a bubble carries none.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (idex_bubble) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= a_ex_hit ? 2'b01 : (a_mem_hit ? 2'b10 : 2'b00);
      fwd_b_q <= b_ex_hit ? 2'b01 : (b_mem_hit ? 2'b10 : 2'b00);
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign hz_err    = hz_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
// Expectations follow PIPE_FORWARDING_EN when the bundle is built with it.

module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int MS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs, id_use_rt, ex_we, ex_is_load, mem_we, br_taken;
  logic [AW-1:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic          pc_hold, ifid_hold, ifid_flush, idex_bubble, hz_err;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .MAX_STALL(MS)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wreg(ex_wreg), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .mem_wreg(mem_wreg), .mem_we(mem_we), .br_taken(br_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hz_err(hz_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          err;
    logic [1:0]    fa;
    logic [1:0]    fb;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]    m_st, m_fa, m_fb, m_fa_n, m_fb_n;
  logic [CW-1:0] m_sc, m_fc;
  int            m_consec;
  logic          m_err, m_hz, m_hold, m_flush, m_bubble;

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic model_eval();
    logic ae, be, am, bm;
    ae = id_valid && id_use_rs && ex_we  && ex_wreg  == id_rs && id_rs != 0;
    be = id_valid && id_use_rt && ex_we  && ex_wreg  == id_rt && id_rt != 0;
    am = id_valid && id_use_rs && mem_we && mem_wreg == id_rs && id_rs != 0;
    bm = id_valid && id_use_rt && mem_we && mem_wreg == id_rt && id_rt != 0;
    if (FWD) begin
      m_hz   = ex_is_load && (ae || be);
      m_fa_n = ae ? 2'd1 : am ? 2'd2 : 2'd0;
      m_fb_n = be ? 2'd1 : bm ? 2'd2 : 2'd0;
    end else begin
      m_hz   = ae || be || am || bm;
      m_fa_n = 2'd0;
      m_fb_n = 2'd0;
    end
    m_flush  = br_taken;
    m_hold   = !br_taken && m_hz;
    m_bubble = br_taken || m_hz;
    if (m_bubble) begin
      m_fa_n = 2'd0;
      m_fb_n = 2'd0;
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sc = 0; m_fc = 0; m_consec = 0; m_err = 0; m_fa = 0; m_fb = 0;
    exp_q.delete();
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                       input int exw, input logic exwe, input logic exld,
                       input int memw, input logic memwe, input logic br);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_use_rs = urs; id_use_rt = urt;
    ex_wreg = AW'(exw); ex_we = exwe; ex_is_load = exld;
    mem_wreg = AW'(memw); mem_we = memwe; br_taken = br;
    #1;
    model_eval();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model for the current inputs, queue its prediction, then clock the DUT.
  task automatic tick();
    m_st = br_taken ? 2'd2 : m_hz ? 2'd1 : 2'd0;
    if (m_hold && m_sc != '1) m_sc = m_sc + 1'b1;
    if (br_taken && m_fc != '1) m_fc = m_fc + 1'b1;
    if (m_hold) begin
      if (m_consec + 1 > MS) m_err = 1'b1;
      m_consec++;
    end else begin
      m_consec = 0;
    end
    m_fa = m_fa_n;
    m_fb = m_fb_n;
    exp_q.push_back('{m_st, m_sc, m_fc, m_err, m_fa, m_fb});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 8, 0, 1, 0, 8, 1, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    checks++;
    if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b, state, stall_cnt, flush_cnt, hz_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got hold=%b ifid_hold=%b flush=%b bubble=%b fa=%b fb=%b st=%b sc=%0d fc=%0d err=%b, expected all 0",
               pc_hold, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b, state, stall_cnt, flush_cnt, hz_err);
    end
    reset = 1'b0;
    model_reset();
    idle();
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b}, e);
    end
  endtask

  task automatic test_stall();
    do_reset();
    if (FWD) begin
      drive(1, 8, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      checks++;
      if ({pc_hold, ifid_hold, idex_bubble, ifid_flush} !== 4'b1110) begin
        errors++;
        $display("FAIL load_use_comb: got %b expected 1110", {pc_hold, ifid_hold, idex_bubble, ifid_flush});
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (state !== 2'b01 || stall_cnt !== CW'(1) || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
        errors++;
        $display("FAIL load_use_regs: got st=%b sc=%0d expected st=01 sc=1", state, stall_cnt);
      end
      drive(1, 8, 0, 1, 0, 0, 0, 0, 8, 1, 0);
      checks++;
      if (pc_hold !== 1'b0) begin
        errors++;
        $display("FAIL load_use_single_cycle: got pc_hold=%b expected 0", pc_hold);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (fwd_a !== 2'b10 || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
        errors++;
        $display("FAIL fwd_a_mem: got fwd_a=%b expected 10", fwd_a);
      end
    end else begin
      drive(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
      checks++;
      if ({pc_hold, ifid_hold, idex_bubble} !== 3'b111) begin
        errors++;
        $display("FAIL raw_ex_stall: got %b expected 111", {pc_hold, ifid_hold, idex_bubble});
      end
      tick();
      void'(exp_q.pop_front());
      drive(1, 5, 0, 1, 0, 0, 0, 0, 5, 1, 0);
      checks++;
      if (pc_hold !== 1'b1) begin
        errors++;
        $display("FAIL raw_mem_stall: got pc_hold=%b expected 1", pc_hold);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (stall_cnt !== CW'(2) || hz_err !== 1'b0 || state !== 2'b01 || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
        errors++;
        $display("FAIL raw_two_stalls: got sc=%0d err=%b st=%b expected sc=2 err=0 st=01", stall_cnt, hz_err, state);
      end
      idle();
      checks++;
      if (pc_hold !== 1'b0) begin
        errors++;
        $display("FAIL raw_release: got pc_hold=%b expected 0", pc_hold);
      end
      tick();
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_fwd_ex();
    do_reset();
    drive(1, 0, 9, 0, 1, 9, 1, 0, 0, 0, 0);
    checks++;
    if (pc_hold !== !FWD) begin
      errors++;
      $display("FAIL ex_alu_hold: got pc_hold=%b expected %b", pc_hold, !FWD);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (fwd_b !== (FWD ? 2'b01 : 2'b00) || fwd_a !== 2'b00 || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
      errors++;
      $display("FAIL fwd_b_ex: got fwd_a=%b fwd_b=%b expected fwd_b=%b", fwd_a, fwd_b, FWD ? 2'b01 : 2'b00);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 8, 0, 1, 0, 8, 1, 1, 0, 0, 1);
    checks++;
    if ({ifid_flush, idex_bubble, pc_hold, ifid_hold} !== 4'b1100) begin
      errors++;
      $display("FAIL branch_comb: got flush/bubble/hold/ifid_hold=%b expected 1100", {ifid_flush, idex_bubble, pc_hold, ifid_hold});
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (flush_cnt !== CW'(1) || state !== 2'b10 || stall_cnt !== CW'(0) || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
      errors++;
      $display("FAIL branch_regs: got fc=%0d st=%b sc=%0d expected fc=1 st=10 sc=0", flush_cnt, state, stall_cnt);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0);
    checks++;
    if ({pc_hold, idex_bubble} !== 2'b00) begin
      errors++;
      $display("FAIL reg0_no_stall: got hold/bubble=%b expected 00", {pc_hold, idex_bubble});
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || state !== 2'b00 || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
      errors++;
      $display("FAIL reg0_fwd: got fwd_a=%b fwd_b=%b st=%b expected 00 00 00", fwd_a, fwd_b, state);
    end
  endtask

  task automatic test_hz_err();
    do_reset();
    drive(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    for (int i = 1; i <= MS + 1; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (hz_err !== (i > MS) || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
        errors++;
        $display("FAIL hz_err_stall%0d: got err=%b sc=%0d expected err=%b", i, hz_err, stall_cnt, i > MS);
      end
    end
    idle();
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hz_err !== 1'b1 || state !== 2'b00 || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
      errors++;
      $display("FAIL hz_err_sticky: got err=%b st=%b expected err=1 st=00", hz_err, state);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      void'(exp_q.pop_front());
    end
    drive(1, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      void'(exp_q.pop_front());
    end
    checks++;
    if (flush_cnt !== '1 || stall_cnt !== '1 || hz_err !== 1'b1) begin
      errors++;
      $display("FAIL counter_saturate: got fc=%0d sc=%0d err=%b expected fc=15 sc=15 err=1", flush_cnt, stall_cnt, hz_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 6, 0, 1, 0, 6, 1, 1, 0, 0, 0);
    tick();
    void'(exp_q.pop_front());
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({pc_hold, ifid_hold, idex_bubble, state, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: got hold=%b bubble=%b st=%b sc=%0d expected all 0", pc_hold, idex_bubble, state, stall_cnt);
    end
    #1;
    reset = 1'b0;
    model_reset();
    idle();
    tick();
    e = exp_q.pop_front();
    checks++;
    if (state !== 2'b00 || {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
      errors++;
      $display("FAIL reset_mid_restart: got %h expected %h", {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b}, e);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      checks++;
      if ({pc_hold, ifid_hold, ifid_flush, idex_bubble} !== {m_hold, m_hold, m_flush, m_bubble}) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got %b expected %b", i, {pc_hold, ifid_hold, ifid_flush, idex_bubble},
                 {m_hold, m_hold, m_flush, m_bubble});
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b} !== e) begin
        errors++;
        $display("FAIL rand_regs[%0d]: got %h expected %h", i, {state, stall_cnt, flush_cnt, hz_err, fwd_a, fwd_b}, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    test_reset();
    test_stall();
    test_fwd_ex();
    test_branch();
    test_reg_zero();
    test_hz_err();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
